// File: rtl/relu_batch_sequencer_if.sv
// Host and ReLU-unit signal bundle for relu_batch_sequencer.
//   Host side  : wr_en/wr_addr/wr_data load the input buffer; start/len launch a
//                batch; busy/done/err_timeout report status; rd_addr/rd_data read
//                the result buffer (1-cycle registered latency).
//   ReLU side  : u_valid_in/u_data_in issue one operand; u_valid_out/u_data_out
//                return one result.
// The slave modport is the sequencer's view; master is the environment's view.
interface relu_batch_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              err_timeout;
  logic              u_valid_in;
  logic [7:0]        u_data_in;
  logic              u_valid_out;
  logic [7:0]        u_data_out;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  modport slave (
    input  wr_en, wr_addr, wr_data, start, len, u_valid_out, u_data_out, rd_addr,
    output busy, done, err_timeout, u_valid_in, u_data_in, rd_data
  );

  modport master (
    output wr_en, wr_addr, wr_data, start, len, u_valid_out, u_data_out, rd_addr,
    input  busy, done, err_timeout, u_valid_in, u_data_in, rd_data
  );
endinterface

// File: rtl/relu_batch_sequencer.sv
// relu_batch_sequencer: holds a batch of signed int8 activations, issues them one
// at a time to a multicycle ReLU unit (no backpressure, drops input while busy),
// and stores each result in a result buffer.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : relu_batch_sequencer_if.slave (host load/start/status/readback and
//            the ReLU valid_in/valid_out handshake)
// Only one operand is ever outstanding: the next issue waits for the previous
// result, or for the TIMEOUT-cycle abort.
module relu_batch_sequencer #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  relu_batch_sequencer_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [7:0]        r_inbuf  [DEPTH];
  logic [7:0]        r_resbuf [DEPTH];
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic [7:0]        r_rd_data;

  logic [ADDR_W:0]   w_len_eff;
  logic [ADDR_W:0]   w_idx_next;
  logic              w_last_wait;

  assign w_len_eff   = (bus.len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : bus.len;
  assign w_idx_next  = r_idx + (ADDR_W+1)'(1);
  // r_cnt counts completed WAIT cycles, so the abort fires on the TIMEOUT-th one
  assign w_last_wait = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = (w_len_eff != '0) ? S_ISSUE : S_DONE;
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.u_valid_out)  w_next = (w_idx_next < r_len) ? S_ISSUE : S_DONE;
        else if (w_last_wait) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_len <= w_len_eff;
            r_err <= 1'b0;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (bus.u_valid_out)  r_idx <= w_idx_next;
          else if (w_last_wait) r_err <= 1'b1;
          else                  r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DONE:  r_idx <= '0;
        default: ;
      endcase
    end
  end

  // Buffer storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.wr_en)
      r_inbuf[bus.wr_addr] <= bus.wr_data;
    if (r_state == S_WAIT && bus.u_valid_out)
      r_resbuf[r_idx[ADDR_W-1:0]] <= bus.u_data_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= r_resbuf[bus.rd_addr];
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.err_timeout = r_err;
  assign bus.u_valid_in  = (r_state == S_ISSUE);
  assign bus.u_data_in   = (r_state == S_ISSUE) ? r_inbuf[r_idx[ADDR_W-1:0]] : '0;
  assign bus.rd_data     = r_rd_data;

endmodule

// File: tb/tb_relu_batch_sequencer.sv
module tb_relu_batch_sequencer;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  relu_batch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  relu_batch_sequencer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] relu(input logic [7:0] x);
    return x[7] ? 8'd0 : x;
  endfunction

  // ---------------- 3-cycle ReLU unit environment ----------------
  logic       relu_en = 1'b1;
  logic       samp_v = 1'b0, d1v = 1'b0, d2v = 1'b0, pv = 1'b0;
  logic [7:0] samp_d = '0, d1d = '0, d2d = '0, pd = '0;
  logic       inj_v = 1'b0;
  logic [7:0] inj_d = '0;

  always @(negedge clk) begin
    samp_v = bus.u_valid_in;
    samp_d = bus.u_data_in;
  end

  always @(posedge clk) begin
    #1;
    pv  = d2v;
    pd  = d2d;
    d2v = d1v;
    d2d = d1d;
    d1v = samp_v & relu_en;
    d1d = relu(samp_d);
  end

  assign bus.u_valid_out = pv | inj_v;
  assign bus.u_data_out  = inj_v ? inj_d : pd;

  // ---------------- behavioural model ----------------
  // A batch started at edge count k: element i issues in cycle k+4i, result i is
  // stored at edge k+4i+4, done sits in cycle k+4n (or k for n=0); a silent unit
  // gives one issue and done in cycle k+TIMEOUT+1 with err_timeout set.
  int         cyc = 0;
  bit         m_active = 0;
  int         m_k = 0, m_n = 0, m_done = 0, md = 0;
  bit         m_resp = 0, m_to = 0;
  logic [7:0] m_in  [DEPTH];
  logic [7:0] m_res [DEPTH];
  bit         m_res_k [DEPTH];
  logic [7:0] exp_rd = '0;
  bit         exp_rd_k = 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      exp_rd   = '0;
      exp_rd_k = 1;
    end else begin
      cyc++;
      exp_rd   = m_res[bus.rd_addr];
      exp_rd_k = m_res_k[bus.rd_addr];
      if (m_active && m_resp) begin
        md = cyc - m_k;
        if (md > 0 && md % 4 == 0 && md / 4 <= m_n) begin
          m_res[md/4-1]   = relu(m_in[md/4-1]);
          m_res_k[md/4-1] = 1;
        end
      end
      if (!m_active || cyc > m_done + 1) begin
        if (bus.wr_en) m_in[bus.wr_addr] = bus.wr_data;
        if (bus.start) begin
          m_active = 1;
          m_k      = cyc;
          m_n      = (int'(bus.len) > DEPTH) ? DEPTH : int'(bus.len);
          m_resp   = relu_en;
          if (m_n == 0) begin
            m_done = cyc; m_to = 0;
          end else if (relu_en) begin
            m_done = cyc + 4 * m_n; m_to = 0;
          end else begin
            m_done = cyc + TIMEOUT + 1; m_to = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int         cd, n_iss;
  bit         e_busy, e_done, e_vin, e_err;
  logic [7:0] e_data;
  int         n_vin = 0, n_busy = 0, done_at = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy",  int'(bus.busy), 0);
      chk("rst_done",  int'(bus.done), 0);
      chk("rst_err",   int'(bus.err_timeout), 0);
      chk("rst_vin",   int'(bus.u_valid_in), 0);
      chk("rst_din",   int'(bus.u_data_in), 0);
      chk("rst_rdata", int'(bus.rd_data), 0);
    end else begin
      cd     = cyc - m_k;
      n_iss  = m_resp ? m_n : ((m_n > 0) ? 1 : 0);
      e_busy = m_active && cyc >= m_k && cyc <= m_done;
      e_done = m_active && cyc == m_done;
      e_vin  = m_active && cd >= 0 && cd % 4 == 0 && cd / 4 < n_iss;
      e_data = e_vin ? m_in[cd/4] : 8'd0;
      e_err  = m_active && m_to && cyc >= m_done;
      chk("busy",        int'(bus.busy), int'(e_busy));
      chk("done",        int'(bus.done), int'(e_done));
      chk("u_valid_in",  int'(bus.u_valid_in), int'(e_vin));
      chk("u_data_in",   int'(bus.u_data_in), int'(e_data));
      chk("err_timeout", int'(bus.err_timeout), int'(e_err));
      if (exp_rd_k) chk("rd_data", int'(bus.rd_data), int'(exp_rd));
      if (bus.u_valid_in) n_vin++;
      if (bus.busy)       n_busy++;
      if (bus.done)       done_at = cyc;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(a);
    bus.wr_data = 8'(d);
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic start_batch(input int l, output int k);
    n_vin   = 0;
    n_busy  = 0;
    done_at = -1;
    bus.start = 1'b1;
    bus.len   = (ADDR_W+1)'(l);
    tick();
    k = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (m_active && cyc <= m_done && b < 300) begin
      tick();
      b++;
    end
    if (b >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: batch still running after %0d cycles", b);
    end
  endtask

  task automatic read_res(input int a, output int v);
    bus.rd_addr = ADDR_W'(a);
    tick();
    tick();
    v = int'(bus.rd_data);
  endtask

  // ---------------- stimulus ----------------
  int k, v;
  int exp1 [5] = '{0, 0, 7, 0, 127};
  int ld1  [5] = '{-5, 0, 7, -128, 127};

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.len = '0; bus.rd_addr = '0;
    foreach (m_res_k[i]) m_res_k[i] = 0;
    #2;
    chk("reset_busy_lit", int'(bus.busy), 0);
    chk("reset_vin_lit",  int'(bus.u_valid_in), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) load(i, int'($urandom_range(0, 255)));

    // basic batch with mixed signs
    for (int i = 0; i < 5; i++) load(i, ld1[i]);
    start_batch(5, k);
    wait_idle();
    chk("t1_done_cycle", done_at, k + 20);
    chk("t1_issues", n_vin, 5);
    chk("t1_err", int'(bus.err_timeout), 0);
    for (int i = 0; i < 5; i++) begin
      read_res(i, v);
      chk("t1_result", v, exp1[i]);
    end

    // empty batch
    start_batch(0, k);
    wait_idle();
    chk("t2_done_cycle", done_at, k);
    chk("t2_issues", n_vin, 0);
    chk("t2_busy_cycles", n_busy, 1);

    // silent unit -> abort
    relu_en = 1'b0;
    start_batch(3, k);
    wait_idle();
    chk("t3_issues", n_vin, 1);
    chk("t3_done_cycle", done_at, k + TIMEOUT + 1);
    chk("t3_err_set", int'(bus.err_timeout), 1);
    relu_en = 1'b1;
    start_batch(1, k);
    chk("t3_err_cleared", int'(bus.err_timeout), 0);
    wait_idle();

    // spurious u_valid_out in IDLE
    bus.rd_addr = 4'd2;
    inj_v = 1'b1; inj_d = 8'h55;
    tick();
    inj_v = 1'b0;
    tick();
    read_res(2, v);
    chk("t6_idle_addr2", v, 7);
    read_res(0, v);
    chk("t6_idle_addr0", v, 0);

    // spurious u_valid_out during ISSUE
    load(0, 9);
    load(1, 200);
    start_batch(2, k);
    inj_v = 1'b1; inj_d = 8'h66;
    tick();
    inj_v = 1'b0;
    wait_idle();
    read_res(0, v);
    chk("t6_issue_addr0", v, 9);
    read_res(1, v);
    chk("t6_issue_addr1", v, 0);

    // oversize len clamps; start/wr_en mid-batch ignored
    for (int i = 0; i < DEPTH; i++) load(i, int'($urandom_range(0, 255)));
    start_batch(31, k);
    repeat (6) tick();
    bus.start = 1'b1; bus.len = 5'd2;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd15; bus.wr_data = 8'h7e;
    tick();
    bus.wr_en = 1'b0;
    wait_idle();
    chk("t4_issues", n_vin, 16);
    chk("t4_done_cycle", done_at, k + 64);

    // reset in the 2nd WAIT of a len=4 batch
    start_batch(4, k);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("t5_busy", int'(bus.busy), 0);
    chk("t5_vin",  int'(bus.u_valid_in), 0);
    chk("t5_rd",   int'(bus.rd_data), 0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    start_batch(2, k);
    wait_idle();
    chk("t5_issues_after", n_vin, 2);
    chk("t5_done_after", done_at, k + 8);

    // randomized batches
    for (int it = 0; it < 25; it++) begin
      for (int j = 0; j < int'($urandom_range(0, 4)); j++)
        load(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)));
      relu_en = ($urandom_range(0, 5) != 0);
      start_batch(int'($urandom_range(0, 31)), k);
      wait_idle();
      relu_en = 1'b1;
      read_res(int'($urandom_range(0, DEPTH - 1)), v);
      read_res(int'($urandom_range(0, DEPTH - 1)), v);
    end

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
